// File: rtl/mem_access_unit.sv
//==============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator for a word-only data memory. Sub-word
//               stores use read-modify-write; loads are lane-extracted and
//               sign- or zero-extended.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wbuf;

    logic                w_accept;
    logic                w_misalign;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_merged;
    logic [31:0]         w_load;

    assign w_accept   = req_valid && req_ready;
    assign w_misalign = (req_size == 2'b11) ||
                        (req_size == c_size_half && req_addr[0]) ||
                        (req_size == c_size_word && req_addr[1:0] != 2'b00);

    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = r_wbuf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                // Misaligned requests are answered from IDLE without touching memory
                if (req_valid && !w_misalign) begin
                    w_next = (req_write && req_size == c_size_word) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                mem_read = 1'b1;
                w_next   = S_CAP;
            end
            S_CAP: begin
                w_next = r_write ? S_WR : S_IDLE;
            end
            S_WR: begin
                mem_write = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Lane selection: little-endian, byte lane = addr[1:0], half lane = addr[1]
    always_comb begin
        w_merged = mem_rdata;
        w_byte   = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half   = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load   = mem_rdata;
        case (r_size)
            c_size_byte: begin
                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wbuf[7:0];
                w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            end
            c_size_half: begin
                w_merged[{r_addr[1], 4'b0000} +: 16] = r_wbuf[15:0];
                w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
            end
            default: begin
                w_merged = mem_rdata;
                w_load   = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wbuf       <= 32'h0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            misalign_err <= 1'b0;
            if (w_accept) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wbuf     <= req_wdata;
                if (w_misalign) begin
                    rsp_valid    <= 1'b1;
                    misalign_err <= 1'b1;
                end
            end
            if (r_state == S_CAP) begin
                if (r_write) begin
                    r_wbuf <= w_merged;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= w_load;
                end
            end
            if (r_state == S_WR) begin
                rsp_valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// Module      : tb_mem_access_unit
// Description : Directed bench for mem_access_unit with a per-cycle
//               expectation schedule derived from a transaction-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int c_depth = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misalign_err(misalign_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-only memory device with registered read data
    logic [31:0] sim_mem [0:63];
    always @(posedge clk) begin
        if (mem_write) sim_mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem_read ? sim_mem[mem_addr[7:2]] : 32'h0;
    end

    // Reference state and per-cycle expectation schedule
    logic [31:0] model_mem [0:63];
    bit          e_ready [0:c_depth-1];
    bit          e_read  [0:c_depth-1];
    bit          e_write [0:c_depth-1];
    bit          e_rsp   [0:c_depth-1];
    bit          e_err   [0:c_depth-1];
    logic [31:0] e_rdata [0:c_depth-1];
    logic [31:0] e_addr  [0:c_depth-1];
    logic [31:0] e_wdata [0:c_depth-1];
    int          model_free = 0;
    int          last_acc = 0;
    int          saved_idx = 0;
    logic [31:0] saved_word = 32'h0;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        last_err = 1'b0;
    int          n_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input int off, input bit uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * off));
        h = 16'(word >> (8 * off));
        if (sz == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return word;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] sz,
                                                input int off, input logic [31:0] data);
        logic [31:0] mask;
        mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
        return (old & ~mask) | ((data << (8 * off)) & mask);
    endfunction

    task automatic set_idle(input int k);
        e_ready[k] = 1'b1; e_read[k] = 1'b0; e_write[k] = 1'b0;
        e_rsp[k] = 1'b0; e_err[k] = 1'b0; e_rdata[k] = 32'h0;
        e_addr[k] = 32'h0; e_wdata[k] = 32'h0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready[cyc]));
            chk("mem_read", 32'(mem_read), 32'(e_read[cyc]));
            chk("mem_write", 32'(mem_write), 32'(e_write[cyc]));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp[cyc]));
            chk("misalign_err", 32'(misalign_err), 32'(e_err[cyc]));
            if (e_rsp[cyc]) chk("rsp_rdata", rsp_rdata, e_rdata[cyc]);
            if (e_read[cyc] || e_write[cyc]) chk("mem_addr", mem_addr, e_addr[cyc]);
            if (e_write[cyc]) chk("mem_wdata", mem_wdata, e_wdata[cyc]);
            if (rsp_valid) begin
                last_rdata = rsp_rdata;
                last_err   = misalign_err;
            end
            if (mem_write) begin
                last_wdata = mem_wdata;
                n_wr++;
            end
        end
    end

    // Holds the request until the model says the unit is ready, then schedules it
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int c;
        int idx;
        int off;
        logic [31:0] old;
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        while (cyc < model_free) @(posedge clk) #1;
        c   = cyc;
        idx = int'(addr[7:2]);
        off = int'(addr[1:0]);
        old = model_mem[idx];
        if (sz == 2'b11 || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && off != 0)) begin
            e_rsp[c+1] = 1'b1; e_err[c+1] = 1'b1; e_rdata[c+1] = 32'h0;
            model_free = c + 1;
        end else if (!wr) begin
            e_ready[c+1] = 1'b0; e_ready[c+2] = 1'b0;
            e_read[c+1] = 1'b1; e_addr[c+1] = {addr[31:2], 2'b00};
            e_rsp[c+3] = 1'b1; e_rdata[c+3] = model_load(old, sz, off, uns);
            model_free = c + 3;
        end else if (sz == 2'b10) begin
            e_ready[c+1] = 1'b0; e_write[c+1] = 1'b1;
            e_addr[c+1] = addr; e_wdata[c+1] = wd;
            e_rsp[c+2] = 1'b1; e_rdata[c+2] = 32'h0;
            model_mem[idx] = wd;
            model_free = c + 2;
        end else begin
            for (int k = 1; k <= 3; k++) e_ready[c+k] = 1'b0;
            e_read[c+1] = 1'b1; e_addr[c+1] = {addr[31:2], 2'b00};
            e_write[c+3] = 1'b1; e_addr[c+3] = {addr[31:2], 2'b00};
            e_wdata[c+3] = model_merge(old, sz, off, wd);
            e_rsp[c+4] = 1'b1; e_rdata[c+4] = 32'h0;
            saved_idx = idx; saved_word = old;
            model_mem[idx] = e_wdata[c+3];
            model_free = c + 4;
        end
        last_acc = c;
        @(posedge clk) #1;
    endtask

    task automatic drop();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc <= model_free) @(posedge clk) #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        sim_mem[idx]  <= v;
        model_mem[idx] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int wr_before;
        for (int k = 0; k < c_depth; k++) set_idle(k);
        for (int k = 0; k < 64; k++) preload(k, 32'h0);
        preload(8'h20 >> 2, 32'h1122_3344);
        preload(8'h30 >> 2, 32'h80F0_7F01);
        preload(8'h40 >> 2, 32'h1234_5678);
        preload(8'h50 >> 2, 32'hCAFE_F00D);

        @(posedge clk) #1;
        chk_en = 1'b1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        reset = 1'b0;
        model_free = cyc;
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);

        // Word round trip
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF); drop(); wait_done();
        chk("sw wdata", last_wdata, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); drop(); wait_done();
        chk("lw rdata", last_rdata, 32'hDEAD_BEEF);

        // Byte store read-modify-write
        issue(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAA); drop(); wait_done();
        chk("sb merged", last_wdata, 32'h11AA_3344);

        // Load extension
        issue(1'b0, 2'b00, 1'b0, 32'h33, 32'h0); drop(); wait_done();
        chk("lb", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b1, 32'h33, 32'h0); drop(); wait_done();
        chk("lbu", last_rdata, 32'h0000_0080);
        issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0); drop(); wait_done();
        chk("lh", last_rdata, 32'hFFFF_80F0);
        issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0); drop(); wait_done();
        chk("lhu", last_rdata, 32'h0000_7F01);

        // Misaligned requests
        issue(1'b0, 2'b01, 1'b0, 32'h31, 32'h0); drop(); wait_done();
        chk("misalign lh", 32'(last_err), 32'h1);
        issue(1'b0, 2'b10, 1'b0, 32'h32, 32'h0); drop(); wait_done();
        chk("misalign lw", 32'(last_err), 32'h1);
        issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h5555_5555); drop(); wait_done();
        chk("misalign size3", 32'(last_err), 32'h1);

        // Back-to-back with req_valid held
        issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        drop(); wait_done();
        chk("b2b lw", last_rdata, 32'hBEEF_5678);
        chk("b2b err", 32'(last_err), 32'h0);

        // Reset during CAP of a byte store
        wr_before = n_wr;
        issue(1'b1, 2'b00, 1'b0, 32'h50, 32'h0000_0077); drop();
        c = last_acc;
        @(posedge clk) #1;
        reset = 1'b1;
        for (int k = c + 3; k < c + 8; k++) set_idle(k);
        model_mem[saved_idx] = saved_word;
        model_free = c + 3;
        @(posedge clk) #1;
        reset = 1'b0;
        chk("post-reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post-reset req_ready", 32'(req_ready), 32'h1);
        repeat (5) @(posedge clk) #1;
        chk("post-reset writes", 32'(n_wr), 32'(wr_before));
        chk("post-reset mem 0x50", sim_mem[8'h50 >> 2], 32'hCAFE_F00D);

        // A fresh access after reset still works
        issue(1'b0, 2'b00, 1'b1, 32'h51, 32'h0); drop(); wait_done();
        chk("lbu after reset", last_rdata, 32'h0000_00F0);

        for (int k = 4; k <= 20; k += 4) chk("final memory", sim_mem[k], model_mem[k]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator placed between the pipeline MEM stage and the word-only data memory. Accepts byte, halfword and word loads and stores and translates each into aligned 32-bit memory reads and writes. Sub-word stores use read-modify-write; loads are lane-extracted and sign- or zero-extended. Stalls the requester through a ready signal until the access finishes.

## Interface
- ADDR_W, 32, request and memory address width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- misalign_err  out  1  qualified by rsp_valid; access rejected.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  write word.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  memory read word, registered by memory (valid the cycle after mem_read, forced to 0 by memory in any non-write cycle with mem_read low).

## Operation
- States: IDLE, RD, CAP, WR.
- Accept = req_valid && req_ready at a clk edge. All req_* fields are latched on accept and ignored otherwise. req_valid while not ready is ignored; requester holds it.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11. Stays in IDLE, no memory access. Next cycle: rsp_valid=1, misalign_err=1, rsp_rdata=0.
- Load: IDLE→RD→CAP→IDLE.
  - In RD: mem_read=1.
  - In CAP: mem_rdata is sampled and extracted into rsp_rdata.
- Word store: IDLE→WR→IDLE. In WR: mem_write=1, mem_wdata=req_wdata.
- Sub-word store: IDLE→RD→CAP→WR→IDLE.
  - In CAP: mem_rdata is merged into the write buffer, replacing only the target lane.
  - In WR: mem_write=1.
- Lanes are little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane h = addr[1] occupies bits [16h+15:16h].
- Load extension: bit 7 (byte) or bit 15 (half) replicated when req_unsigned=0; zeros when req_unsigned=1. Word loads pass through unchanged.
- mem_read and mem_write are never high together. mem_addr and mem_wdata hold their latched values outside RD/WR; they are only meaningful under a strobe.
- rsp_valid and misalign_err are registered. Both are high for exactly one cycle, which is the first IDLE cycle after completion. A new request may be accepted in that same cycle.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; misalign_err=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- Accept at cycle 0. Then:
  - Load: mem_read in cycle 1, capture in cycle 2, rsp_valid in cycle 3.
  - Word store: mem_write in cycle 1, rsp_valid in cycle 2.
  - Sub-word store: mem_read in cycle 1, merge in cycle 2, mem_write in cycle 3, rsp_valid in cycle 4.
  - Misaligned: rsp_valid in cycle 1.
- Throughput: one access in flight. req_ready is low in RD, CAP and WR.
- Back-to-back: a request accepted in the rsp_valid cycle starts normally. The response pulse is not extended.
- Reset mid-operation: next edge returns to IDLE with all outputs at reset values. No pending mem_write or rsp_valid is issued. A read-modify-write interrupted before WR leaves memory unchanged.

## Test plan
- Word round trip: store 0xDEADBEEF @0x10 → mem_write in cycle 1, mem_addr=0x10, rsp_valid in cycle 2. Load word @0x10 → rsp_rdata=0xDEADBEEF in cycle 3.
- Byte store RMW: memory @0x20 = 0x11223344; store byte 0xAA @0x22 → mem_read in cycle 1, mem_write in cycle 3, mem_wdata=0x11AA3344, rsp_valid in cycle 4.
- Extension: memory @0x30 = 0x80F07F01.
  - lb @0x33 → 0xFFFFFF80; lbu @0x33 → 0x00000080.
  - lh @0x32 → 0xFFFF80F0; lhu @0x30 → 0x00007F01.
- Misalign: lh @0x31, lw @0x32, and size 11 @0x40 → each gives rsp_valid and misalign_err in cycle 1 with no mem_read or mem_write.
- Back-to-back: issue sh 0xBEEF @0x42 and lw @0x40 with req_valid held high. Second accept occurs in the first rsp_valid cycle; lw returns 0xBEEF in its lane over prior contents; req_ready is low throughout RD/CAP/WR.
- Reset in CAP of byte store @0x50 → mem_write never asserted, word @0x50 unchanged, rsp_valid=0, req_ready=1 the cycle after reset.
